// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   - ldr_state_t   : loader FSM state encoding
//   - SYNC_BYTE_DEF : default frame start marker
//   - CNT_W         : width of the frame word-count field
//   - cksum_next()  : running checksum update (XOR of data bytes)
// Optional feature macro: IMEM_LOADER_CKSUM_EN (trailing checksum byte).
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CKSUM  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } ldr_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CNT_W         = 16;

    // XOR-accumulate one data byte into the running checksum.
    function automatic logic [7:0] cksum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs a little-endian byte stream into 32-bit words.
//   clk, rstn   : clock, synchronous active-low reset
//   clr         : synchronous clear of the partial word (new frame)
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word_valid  : high in the cycle the 4th byte of a word is consumed
//   word        : assembled word (first byte in bits 7:0), valid with word_valid
module imem_word_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_r;
    logic [23:0] shift_r;

    // Byte position counter and shift register holding the first three bytes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
        end else if (clr) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            shift_r    <= {byte_data, shift_r[23:8]};
        end else begin
            byte_cnt_r <= byte_cnt_r;
            shift_r    <= shift_r;
        end
    end

    // The 4th byte completes the word directly so the owner can register it at once.
    always_comb begin
        word_valid = byte_valid && (byte_cnt_r == 2'd3);
        word       = {byte_data, shift_r};
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into instruction memory,
// holding the CPU in reset until a frame completes.
// Frame: SYNC_BYTE, N[7:0], N[15:8], N little-endian words, [checksum byte].
//   clk, rstn          : clock, synchronous active-low reset
//   rx_valid/rx_data   : byte stream input; rx_ready accepts (always 1 out of reset)
//   im_we/im_addr/im_wdata : one-cycle instruction-memory write
//   cpu_rstn           : active-low CPU reset, released the cycle after DONE
//   done / err         : status of the last load
// Optional feature macro: IMEM_LOADER_CKSUM_EN adds the trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rstn,
    output logic              done,
    output logic              err
);

    // Largest legal word count: the full memory capacity.
    localparam logic [CNT_W:0] CAP = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

    ldr_state_t        state_r, state_s;
    logic              rx_ready_r, im_we_r, cpu_rstn_r, done_r, err_r;
    logic [ADDR_W-1:0] im_addr_r, word_idx_r;
    logic [31:0]       im_wdata_r;
    logic [CNT_W-1:0]  cnt_r, n_full_s;
    logic              acc_s, start_s, last_word_s, word_valid_s;
    logic [31:0]       word_s;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        cksum_r;
`endif

    imem_word_assembler u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (start_s),
        .byte_valid (acc_s && (state_r == ST_DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Handshake, frame-start detection and last-word detection.
    always_comb begin
        acc_s       = rx_valid && rx_ready_r;
        n_full_s    = {rx_data, cnt_r[7:0]};
        start_s     = acc_s && (rx_data == SYNC_BYTE) &&
                      ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
        last_word_s = word_valid_s && (CNT_W'(word_idx_r) == (cnt_r - 16'd1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_s) state_s = ST_CNT_LO;
                else         state_s = state_r;
            end
            ST_CNT_LO: begin
                if (acc_s) state_s = ST_CNT_HI;
                else       state_s = state_r;
            end
            ST_CNT_HI: begin
                if (!acc_s)                          state_s = state_r;
                else if ({1'b0, n_full_s} > CAP)     state_s = ST_ERR;
`ifdef IMEM_LOADER_CKSUM_EN
                else if (n_full_s == 16'd0)          state_s = ST_CKSUM;
`else
                else if (n_full_s == 16'd0)          state_s = ST_DONE;
`endif
                else                                 state_s = ST_DATA;
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (last_word_s) state_s = ST_CKSUM;
`else
                if (last_word_s) state_s = ST_DONE;
`endif
                else             state_s = state_r;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (!acc_s)                  state_s = state_r;
                else if (rx_data == cksum_r) state_s = ST_DONE;
                else                         state_s = ST_ERR;
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counters, checksum and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            im_we_r    <= 1'b0;
            im_addr_r  <= '0;
            im_wdata_r <= 32'd0;
            cpu_rstn_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            word_idx_r <= '0;
            cnt_r      <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_r    <= 8'd0;
`endif
        end else begin
            state_r    <= state_s;
            rx_ready_r <= 1'b1;
            im_we_r    <= word_valid_s;
            if (word_valid_s) begin
                im_addr_r  <= word_idx_r;
                im_wdata_r <= word_s;
            end else begin
                im_addr_r  <= im_addr_r;
                im_wdata_r <= im_wdata_r;
            end
            if (start_s) begin
                done_r     <= 1'b0;
                err_r      <= 1'b0;
                cpu_rstn_r <= 1'b0;
                word_idx_r <= '0;
                cnt_r      <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum_r    <= 8'd0;
`endif
            end else begin
                done_r     <= done_r || ((state_s == ST_DONE) && (state_r != ST_DONE));
                err_r      <= err_r  || ((state_s == ST_ERR)  && (state_r != ST_ERR));
                // Release the CPU one cycle after DONE was entered.
                cpu_rstn_r <= cpu_rstn_r || (state_r == ST_DONE);
                // Counter parks on the last word instead of wrapping.
                if (word_valid_s && !last_word_s) word_idx_r <= word_idx_r + ADDR_W'(1'b1);
                else                              word_idx_r <= word_idx_r;
                if (acc_s && (state_r == ST_CNT_LO))      cnt_r <= {cnt_r[15:8], rx_data};
                else if (acc_s && (state_r == ST_CNT_HI)) cnt_r <= n_full_s;
                else                                      cnt_r <= cnt_r;
`ifdef IMEM_LOADER_CKSUM_EN
                if (acc_s && (state_r == ST_DATA)) cksum_r <= cksum_next(cksum_r, rx_data);
                else                               cksum_r <= cksum_r;
`endif
            end
        end
    end

    assign rx_ready = rx_ready_r;
    assign im_we    = im_we_r;
    assign im_addr  = im_addr_r;
    assign im_wdata = im_wdata_r;
    assign cpu_rstn = cpu_rstn_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rstn;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Monitor-owned logs (written only by the monitor process)
    logic [31:0] wr_data_q[$];
    int          wr_addr_q[$];
    int          wr_cyc_q[$];
    int          done_rise_q[$];
    int          cpu_rise_q[$];
    logic        prev_done = 1'b0;
    logic        prev_cpu  = 1'b0;

    // Driver-owned logs
    int          acc_q[$];
    logic [31:0] exp_words[$];

    imem_loader dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rstn (cpu_rstn),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_data_q.push_back(im_wdata);
            wr_addr_q.push_back(int'(im_addr));
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_rise_q.push_back(cyc);
        if (cpu_rstn === 1'b1 && prev_cpu !== 1'b1) cpu_rise_q.push_back(cyc);
        prev_done = done;
        prev_cpu  = cpu_rstn;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one byte (optionally after an idle cycle); returns after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int w;
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        while (rx_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (rx_ready !== 1'b1) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        acc_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic bit pick_gap(input int mode, input bit first);
        if (mode == 1) return !first;
        if (mode == 2) return bit'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // Send a frame built from exp_words (header count n) and check the outcome.
    task automatic run_frame(input string tag, input int n, input bit bad_ck, input int gap_mode);
        logic [7:0] ck;
        logic [7:0] b;
        logic [15:0] n16;
        bit ok;
        int nwr, wb, db, cb, ab;
        wb  = wr_data_q.size();
        db  = done_rise_q.size();
        cb  = cpu_rise_q.size();
        ab  = acc_q.size();
        n16 = 16'(n);
        ck  = 8'h00;
        send_byte(8'hA5, pick_gap(gap_mode, 1'b1));
        send_byte(n16[7:0], pick_gap(gap_mode, 1'b0));
        send_byte(n16[15:8], pick_gap(gap_mode, 1'b0));
        if (n <= 256) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    b  = exp_words[i][8*j +: 8];
                    ck = ck ^ b;
                    send_byte(b, pick_gap(gap_mode, 1'b0));
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            send_byte(bad_ck ? (ck ^ 8'h11) : ck, pick_gap(gap_mode, 1'b0));
`endif
        end
        idle(4);
`ifdef IMEM_LOADER_CKSUM_EN
        ok = (n <= 256) && !bad_ck;
`else
        ok = (n <= 256);
`endif
        nwr = (n <= 256) ? n : 0;
        check_eq({tag, ".nwrites"}, 32'(wr_data_q.size() - wb), 32'(nwr));
        for (int i = 0; i < nwr && (wb + i) < wr_data_q.size(); i++) begin
            check_eq($sformatf("%s.addr[%0d]", tag, i), 32'(wr_addr_q[wb+i]), 32'(i));
            check_eq($sformatf("%s.data[%0d]", tag, i), wr_data_q[wb+i], exp_words[i]);
            check_eq($sformatf("%s.wcyc[%0d]", tag, i), 32'(wr_cyc_q[wb+i]),
                     32'(acc_q[ab + 3 + 4*i + 3]));
        end
        check_eq({tag, ".done"}, 32'(done), 32'(ok));
        check_eq({tag, ".err"}, 32'(err), 32'(!ok));
        check_eq({tag, ".cpu_rstn"}, 32'(cpu_rstn), 32'(ok));
        if (ok) begin
            check_eq({tag, ".rises"}, 32'((done_rise_q.size() > db) && (cpu_rise_q.size() > cb)), 32'd1);
            if ((done_rise_q.size() > db) && (cpu_rise_q.size() > cb))
                check_eq({tag, ".cpu_delay"}, 32'(cpu_rise_q[cb] - done_rise_q[db]), 32'd1);
        end
    endtask

    task automatic rand_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) exp_words.push_back(32'hA5A5A5A5);
            else                            exp_words.push_back($urandom);
        end
    endtask

    initial begin
        int wb;
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst.rx_ready", 32'(rx_ready), 32'd0);
        check_eq("rst.im_we", 32'(im_we), 32'd0);
        check_eq("rst.im_addr", 32'(im_addr), 32'd0);
        check_eq("rst.im_wdata", im_wdata, 32'd0);
        check_eq("rst.cpu_rstn", 32'(cpu_rstn), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.err", 32'(err), 32'd0);
        rstn = 1'b1;
        idle(2);

        // Reference frame: two instructions
        exp_words.delete();
        exp_words.push_back(32'h00000013);
        exp_words.push_back(32'h00100093);
        run_frame("ref", 2, 1'b0, 0);
`ifdef IMEM_LOADER_CKSUM_EN
        run_frame("badck", 2, 1'b1, 0);
`endif

        // Oversized count, then recovery
        run_frame("ovf", 257, 1'b0, 0);
        rand_words(3);
        run_frame("after_ovf", 3, 1'b0, 0);

        // Junk before sync, empty frame
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        exp_words.delete();
        run_frame("empty", 0, 1'b0, 0);

        // Reset in the middle of word 0
        wb = wr_data_q.size();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rx_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        check_eq("midrst.im_we", 32'(im_we), 32'd0);
        check_eq("midrst.rx_ready", 32'(rx_ready), 32'd0);
        check_eq("midrst.done", 32'(done), 32'd0);
        check_eq("midrst.cpu_rstn", 32'(cpu_rstn), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        idle(3);
        check_eq("midrst.nwrites", 32'(wr_data_q.size() - wb), 32'd0);
        check_eq("midrst.idle_done", 32'(done), 32'd0);
        rand_words(3);
        run_frame("midrst_frame", 3, 1'b0, 0);

        // Alternating rx_valid across a 3-word frame
        rand_words(3);
        exp_words[1] = 32'hA5A5A5A5;
        run_frame("toggle", 3, 1'b0, 1);

        // Full-capacity frame
        rand_words(256);
        run_frame("full", 256, 1'b0, 0);

        // Randomized frames with random gaps
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 8);
            rand_words(n);
            run_frame($sformatf("rand%0d", k), n, 1'b0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

endmodule
